mdio_master: RTL and testbench
==============================

# mdio_master

MDIO management-station controller that generates MDC from the system clock and runs single IEEE 802.3 Clause 22 read or write frames toward a PHY or PHY-emulating MDIO slave. It sits directly upstream of the MDIO slave stage: it produces the MDC clock and the preamble/ST/OP/PHYAD/REGAD/TA/data stream that the slave decodes. On reads it captures the 16-bit register value the slave returns. A host-side start/done handshake issues one frame at a time.

## Interface

- CLK_DIV, 20: clk cycles per MDC half-period; MDC period = 2*CLK_DIV clk cycles; legal range 2..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- rdnwr  input  1  1 = read frame (OP=10), 0 = write frame (OP=01); latched on accepted start.
- phy_addr  input  5  PHYAD; latched on accepted start.
- reg_addr  input  5  REGAD; latched on accepted start.
- wr_data  input  16  write payload, MSB first; latched on accepted start.
- busy  output  1  high from cycle after accepted start until the done cycle, inclusive.
- done  output  1  one-clk pulse at frame end.
- rd_data  output  16  captured read data; updated only at done of a read frame.
- mdc  output  1  management clock.
- mdio_i  input  1  bus input (external pull-up: floating reads as 1).
- mdio_o  output  1  bus output data.
- mdio_t  output  1  output enable: 1 = this block drives mdio_o onto the bus, 0 = released.

## Operation

- Divider: div_cnt counts 0..CLK_DIV-1; on CLK_DIV-1 it wraps and mdc toggles. MDC runs continuously after reset. Rise event = clk cycle in which mdc register goes 0->1; fall event = 1->0.
- Frame = 64 bit periods, index 0..63, each bit period starting at a fall event: 0-31 preamble all 1; 32-33 ST=01; 34-35 OP (10 read, 01 write); 36-40 PHYAD MSB first; 41-45 REGAD MSB first; 46-47 TA; 48-63 data MSB first.
- mdio_o/mdio_t change only on fall events (registered in the same clk edge that drives mdc low).
- Write: mdio_t=1 for bits 0-63; TA driven 1,0; data = latched wr_data.
- Read: mdio_t=1 for bits 0-45; mdio_t=0 from bit 46 onward; mdio_o=1 while released. mdio_i sampled on the rise event inside each of bits 48-63 into a shift register, MSB first.
- States: IDLE -> WAIT_FALL (start accepted) -> PREAMBLE (bits 0-31) -> HEADER (32-45) -> TA (46-47) -> DATA (48-63) -> IDLE. A 6-bit bit counter advances on each fall event; transitions occur on fall events at the listed boundaries.
- End: the fall event that would start bit 64 sets mdio_t=0, mdio_o=1, pulses done, loads rd_data (read only), deasserts busy next cycle.
- start while busy=1: ignored, no latching, no queuing. start on the same cycle as done: ignored (busy still 1).
- TA bit 47 on read: mdio_i not checked; no error flag.

## Timing

- Reset values: mdc=0, mdio_o=1, mdio_t=0, busy=0, done=0, rd_data=16'h0000, div_cnt=0, state IDLE.
- rst mid-frame: all of the above on the next clk edge; frame abandoned, no done pulse, rd_data cleared.
- Start latency: busy=1 at start+1 clk; bit 0 begins at the next fall event (at most 2*CLK_DIV clk later).
- Frame duration: exactly 64 MDC periods = 128*CLK_DIV clk from bit-0 fall event to done cycle.
- Back-to-back: a start in the cycle after done (busy=0) is accepted; next bit 0 begins at the following fall event (one MDC period later at the earliest).
- rd_data stable between done pulses; valid in the done cycle.

## Test plan

- Write, CLK_DIV=4, phy 4, reg 0x00, data 0x2100: sample mdio_o on mdc rise -> 32x1, 01, 01, 00100, 00000, 10, 0010_0001_0000_0000; mdio_t=1 throughout; done exactly 512 clk after bit 0 start.
- Read, phy 4, reg 0x03, bus model of the MDIO slave returning 0xD023: rd_data=0xD023 at done; mdio_t=0 from bit 46; OP bits observed 10.
- Read from absent phy 7 (mdio_i held 1): rd_data=0xFFFF, done pulses normally.
- start asserted every cycle while busy with changing addresses: only first request frames; second start after done frames the newly presented address.
- rst asserted at bit 40: next clk mdc=0, mdio_t=0, mdio_o=1, busy=0, no done; new start afterwards produces a clean full frame.
- CLK_DIV=2, two back-to-back reads: mdc period 4 clk, both rd_data values correct, no bit slip at frame boundary.

Source files
------------

// File: rtl/mdio_master.sv
// MDIO Clause 22 management station: free-running MDC divider
// plus a single read/write frame sequencer with start/done handshake.
module mdio_master #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rdnwr,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FALL,
    S_PREAMBLE,
    S_HEADER,
    S_TA,
    S_DATA
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt, bit_nxt, bit_inc;
  logic [4:0]  word_idx;
  logic [31:0] frame;
  logic [15:0] rx_sr;
  logic        rd_op;
  logic        tick, fall_ev, rise_ev, accept;
  logic        o_nxt, t_nxt, done_nxt;

  assign tick     = (div_cnt == DIV_LAST);
  assign fall_ev  = tick & mdc;
  assign rise_ev  = tick & ~mdc;
  assign busy     = (state != S_IDLE) | done;
  assign accept   = start & ~busy;
  assign bit_inc  = bit_cnt + 6'd1;
  // bits 32..63 map MSB-first onto frame[31:0]
  assign word_idx = ~bit_inc[4:0];

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    o_nxt     = mdio_o;
    t_nxt     = mdio_t;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_WAIT_FALL;
      end
      S_WAIT_FALL: begin
        if (fall_ev) begin
          state_nxt = S_PREAMBLE;
          bit_nxt   = '0;
          o_nxt     = 1'b1;
          t_nxt     = 1'b1;
        end
      end
      default: begin
        if (fall_ev) begin
          if (bit_cnt == 6'd63) begin
            state_nxt = S_IDLE;
            o_nxt     = 1'b1;
            t_nxt     = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_inc;
            o_nxt   = bit_inc[5] ? frame[word_idx] : 1'b1;
            t_nxt   = ~(rd_op & (bit_inc >= 6'd46));
            unique case (1'b1)
              bit_inc == 6'd32: state_nxt = S_HEADER;
              bit_inc == 6'd46: state_nxt = S_TA;
              bit_inc == 6'd48: state_nxt = S_DATA;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
      state   <= S_IDLE;
      bit_cnt <= '0;
      frame   <= '0;
      rx_sr   <= '0;
      rd_op   <= 1'b0;
      rd_data <= '0;
      mdio_o  <= 1'b1;
      mdio_t  <= 1'b0;
      done    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 8'd1;
      if (tick) mdc <= ~mdc;
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      mdio_o  <= o_nxt;
      mdio_t  <= t_nxt;
      done    <= done_nxt;
      // reads carry TA/data as ones so the released line idles high
      if (accept) begin
        rd_op <= rdnwr;
        frame <= {2'b01, rdnwr ? 2'b10 : 2'b01, phy_addr, reg_addr,
                  rdnwr ? 18'h3FFFF : {2'b10, wr_data}};
      end
      if (rise_ev && state == S_DATA) rx_sr <= {rx_sr[14:0], mdio_i};
      if (done_nxt && rd_op) rd_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: CLK_DIV=4 and CLK_DIV=2 instances
// driven by a bit-counting MDIO slave model.
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_w, rdnwr_w, busy_w, done_w;
  logic [1:0] mdc_w, mdio_i_w, mdio_o_w, mdio_t_w;
  logic [1:0][4:0]  phy_w, reg_w;
  logic [1:0][15:0] wrd_w, rdd_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start_w[0]), .rdnwr(rdnwr_w[0]),
    .phy_addr(phy_w[0]), .reg_addr(reg_w[0]), .wr_data(wrd_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rd_data(rdd_w[0]),
    .mdc(mdc_w[0]), .mdio_i(mdio_i_w[0]), .mdio_o(mdio_o_w[0]),
    .mdio_t(mdio_t_w[0])
  );

  mdio_master #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .start(start_w[1]), .rdnwr(rdnwr_w[1]),
    .phy_addr(phy_w[1]), .reg_addr(reg_w[1]), .wr_data(wrd_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .rd_data(rdd_w[1]),
    .mdc(mdc_w[1]), .mdio_i(mdio_i_w[1]), .mdio_o(mdio_o_w[1]),
    .mdio_t(mdio_t_w[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sd: data the slave returns, and the rd_data expected at done
  task automatic run_frame(input int k, input bit rd,
                           input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] sd,
                           input bit spam);
    int div, bit_i, since0;
    bit prev, got_done;
    logic [63:0] cap_o, cap_t, exp_o, exp_t;
    logic done_t, done_o;
    div = (k == 0) ? 4 : 2;
    cap_o = 'x;
    cap_t = 'x;
    done_t = 1'bx;
    done_o = 1'bx;
    phy_w[k] = pa;
    reg_w[k] = ra;
    rdnwr_w[k] = rd;
    wrd_w[k] = wd;
    mdio_i_w[k] = 1'b1;
    start_w[k] = 1'b1;
    @(negedge clk);
    if (!spam) start_w[k] = 1'b0;
    chk("busy_after_start", busy_w[k], 1);
    bit_i = -1;
    since0 = 0;
    got_done = 0;
    prev = mdc_w[k];
    for (int cyc = 0; cyc < 300 * div && !got_done; cyc++) begin
      @(negedge clk);
      if (spam) begin
        start_w[k] = 1'b1;
        phy_w[k] = 5'($urandom);
        reg_w[k] = 5'($urandom);
      end
      if (bit_i >= 0) since0++;
      if (done_w[k]) begin
        got_done = 1;
        done_t = mdio_t_w[k];
        done_o = mdio_o_w[k];
      end else if (prev && !mdc_w[k]) begin
        bit_i++;
        mdio_i_w[k] = (bit_i >= 48 && bit_i <= 63) ? sd[63-bit_i] : 1'b1;
      end else if (!prev && mdc_w[k] && bit_i >= 0 && bit_i < 64) begin
        cap_o[63-bit_i] = mdio_o_w[k];
        cap_t[63-bit_i] = mdio_t_w[k];
      end
      prev = mdc_w[k];
    end
    mdio_i_w[k] = 1'b1;
    chk("done_seen", got_done, 1);
    chk("bits_before_done", bit_i, 63);
    chk("frame_clks", since0, 128 * div);
    exp_o = {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, pa, ra,
             rd ? 18'h3FFFF : {2'b10, wd}};
    exp_t = rd ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
    chk("mdio_o_frame", cap_o, exp_o);
    chk("mdio_t_frame", cap_t, exp_t);
    chk("done_mdio_t", done_t, 0);
    chk("done_mdio_o", done_o, 1);
    chk("rd_data", rdd_w[k], sd);
  endtask

  initial begin
    int bi;
    bit pv, seen;
    rst = 1'b1;
    start_w = '0;
    rdnwr_w = '0;
    phy_w = '0;
    reg_w = '0;
    wrd_w = '0;
    mdio_i_w = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_mdc", mdc_w, 2'b00);
    chk("rst_mdio_o", mdio_o_w, 2'b11);
    chk("rst_mdio_t", mdio_t_w, 2'b00);
    chk("rst_busy", busy_w, 2'b00);
    chk("rst_done", done_w, 2'b00);
    chk("rst_rd_data", rdd_w, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // write phy 4 reg 0 data 0x2100; header+data word is 0x5202_2100
    run_frame(0, 0, 5'd4, 5'd0, 16'h2100, 16'h0000, 0);
    chk("write_word_const", {2'b01, 2'b01, 5'd4, 5'd0, 2'b10, 16'h2100},
        64'h5202_2100);
    @(negedge clk);
    run_frame(0, 1, 5'd4, 5'd3, 16'h0000, 16'hD023, 0);
    @(negedge clk);
    run_frame(0, 1, 5'd7, 5'd1, 16'h0000, 16'hFFFF, 0);
    @(negedge clk);

    // start held high with changing addresses for a whole frame
    run_frame(0, 1, 5'd9, 5'h11, 16'h0000, 16'h1234, 1);
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("start_on_done_ignored", busy_w[0], 0);
    @(negedge clk);
    run_frame(0, 1, 5'h1A, 5'h05, 16'h0000, 16'hA5C3, 0);
    @(negedge clk);

    // reset in the middle of bit 40 of a read
    phy_w[0] = 5'd5;
    reg_w[0] = 5'd1;
    rdnwr_w[0] = 1'b1;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    bi = -1;
    pv = mdc_w[0];
    for (int c = 0; c < 1200 && bi < 40; c++) begin
      @(negedge clk);
      if (pv && !mdc_w[0]) bi++;
      pv = mdc_w[0];
    end
    chk("reached_bit40", bi, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mdc", mdc_w[0], 0);
    chk("midrst_mdio_t", mdio_t_w[0], 0);
    chk("midrst_mdio_o", mdio_o_w[0], 1);
    chk("midrst_busy", busy_w[0], 0);
    chk("midrst_done", done_w[0], 0);
    chk("midrst_rd_data", rdd_w[0], 16'h0000);
    seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) seen = 1;
    end
    chk("midrst_quiet", seen, 0);
    run_frame(0, 0, 5'h1F, 5'h1F, 16'h8001, 16'h0000, 0);
    @(negedge clk);

    // CLK_DIV=2 back-to-back reads
    run_frame(1, 1, 5'd1, 5'd2, 16'h0000, 16'h5A5A, 0);
    @(negedge clk);
    chk("b2b_idle", busy_w[1], 0);
    run_frame(1, 1, 5'd3, 5'd4, 16'h0000, 16'h0F0F, 0);
    @(negedge clk);
    chk("b2b_rd_hold", rdd_w[1], 16'h0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
